// File: rtl/mem_access_pkg.sv
// Shared state type, size encodings and alignment helper for mem_access_master.
// The RMW states exist only when MEM_ACCESS_SUBWORD_EN is defined.
package mem_access_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RD_WAIT,
        WR,
        RESP
`ifdef MEM_ACCESS_SUBWORD_EN
        ,
        RMW_RD,
        RMW_WAIT
`endif
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Size 3 has no legal alignment, so it is reported the same way as a misaligned access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lane_unit.sv
// Combinational lane logic: load lane select with sign/zero extension, and store lane merge.
// The merge port and logic are built only when MEM_ACCESS_SUBWORD_EN is defined.
module mem_lane_unit
    import mem_access_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_addr_lo,
    input  logic        i_signed,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_load_data
`ifdef MEM_ACCESS_SUBWORD_EN
    ,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_merged
`endif
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        w_byte      = i_rdata[7:0];
        w_half      = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
        o_load_data = i_rdata;
        case (i_addr_lo)
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            2'd3:    w_byte = i_rdata[31:24];
            default: w_byte = i_rdata[7:0];
        endcase
        case (i_size)
            SZ_BYTE: o_load_data = {{24{i_signed & w_byte[7]}}, w_byte};
            SZ_HALF: o_load_data = {{16{i_signed & w_half[15]}}, w_half};
            default: o_load_data = i_rdata;
        endcase
    end

`ifdef MEM_ACCESS_SUBWORD_EN
    always_comb begin
        o_merged = i_rdata;
        case (i_size)
            SZ_BYTE: begin
                case (i_addr_lo)
                    2'd1:    o_merged[15:8]  = i_wdata[7:0];
                    2'd2:    o_merged[23:16] = i_wdata[7:0];
                    2'd3:    o_merged[31:24] = i_wdata[7:0];
                    default: o_merged[7:0]   = i_wdata[7:0];
                endcase
            end
            SZ_HALF: begin
                if (i_addr_lo[1]) o_merged[31:16] = i_wdata[15:0];
                else              o_merged[15:0]  = i_wdata[15:0];
            end
            default: o_merged = i_wdata;
        endcase
    end
`endif

endmodule

// File: rtl/mem_access_master.sv
// Load/store initiator: turns byte-addressed requests into word transactions on the data memory.
// Define MEM_ACCESS_SUBWORD_EN to support byte/half accesses (read-modify-write stores).
module mem_access_master
    import mem_access_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int WR_TIMEOUT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_wren,
    output logic              mem_gp_we,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_e
);

    localparam int               CNT_W    = $clog2(WR_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WR_TIMEOUT - 1);

    state_t            r_state;
    state_t            w_next_state;
    logic              w_err_next;
    logic              w_req_bad;
    logic              w_accept;
    logic [1:0]        r_size;
    logic [1:0]        r_addr_lo;
    logic              r_signed;
    logic [ADDR_W-3:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic              r_resp_err;
    logic [31:0]       r_resp_rdata;
    logic [CNT_W-1:0]  r_wr_cnt;
    logic [31:0]       w_load_data;
`ifdef MEM_ACCESS_SUBWORD_EN
    logic [31:0]       w_merged;
`endif

    assign w_accept = (r_state == IDLE) && req_valid;

`ifdef MEM_ACCESS_SUBWORD_EN
    assign w_req_bad = is_misaligned(req_size, req_addr[1:0]);
`else
    assign w_req_bad = is_misaligned(req_size, req_addr[1:0]) || (req_size != SZ_WORD);
`endif

    mem_lane_unit u_lane (
        .i_size      (r_size),
        .i_addr_lo   (r_addr_lo),
        .i_signed    (r_signed),
        .i_rdata     (mem_rdata),
        .o_load_data (w_load_data)
`ifdef MEM_ACCESS_SUBWORD_EN
        ,
        .i_wdata     (r_mem_wdata),
        .o_merged    (w_merged)
`endif
    );

    always_comb begin
        w_next_state = r_state;
        w_err_next   = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    if (w_req_bad) begin
                        w_next_state = RESP;
                        w_err_next   = 1'b1;
                    end else if (!req_we) begin
                        w_next_state = RD;
`ifdef MEM_ACCESS_SUBWORD_EN
                    end else if (req_size != SZ_WORD) begin
                        w_next_state = RMW_RD;
`endif
                    end else begin
                        w_next_state = WR;
                    end
                end
            end
            RD:       w_next_state = RD_WAIT;
            RD_WAIT:  w_next_state = RESP;
`ifdef MEM_ACCESS_SUBWORD_EN
            RMW_RD:   w_next_state = RMW_WAIT;
            RMW_WAIT: w_next_state = WR;
`endif
            // Strobes stay up until the memory's write phase is seen or the budget runs out.
            WR: begin
                if (mem_e) begin
                    w_next_state = RESP;
                end else if (r_wr_cnt == CNT_LAST) begin
                    w_next_state = RESP;
                    w_err_next   = 1'b1;
                end
            end
            RESP:     w_next_state = IDLE;
            default:  w_next_state = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    // The datapath registers are reset too, because they drive outputs with defined reset values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_size       <= SZ_WORD;
            r_addr_lo    <= 2'b00;
            r_signed     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
            r_wr_cnt     <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_size      <= req_size;
                r_addr_lo   <= req_addr[1:0];
                r_signed    <= req_signed;
                r_mem_addr  <= req_addr[ADDR_W-1:2];
                r_mem_wdata <= req_wdata;
            end
`ifdef MEM_ACCESS_SUBWORD_EN
            if (r_state == RMW_WAIT) r_mem_wdata <= w_merged;
`endif
            r_wr_cnt     <= (r_state == WR) ? r_wr_cnt + 1'b1 : '0;
            r_resp_err   <= w_err_next;
            r_resp_rdata <= (r_state == RD_WAIT) ? w_load_data : '0;
        end
    end

    assign req_ready  = (r_state == IDLE);
    assign resp_valid = (r_state == RESP);
    assign resp_err   = r_resp_err;
    assign resp_rdata = r_resp_rdata;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign mem_wren   = (r_state == WR);
    assign mem_gp_we  = (r_state == WR);

endmodule
